instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the 16-bit RISC core; feeds instruction words into the decoder/control stage.
- Reads instruction memory one word at a time and detects two-word instructions from opcode In[15:11].
- Assembles {instruction, extension word} and issues it downstream over a valid/ready handshake.
- Owns the PC and supports branch/redirect and downstream backpressure.

Parameters:
- ADDR_W, 16, instruction-memory address / PC width.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_rd  out  1  instruction-memory read strobe.
- imem_addr  out  ADDR_W  read address, valid while imem_rd=1.
- imem_data  in  16  read data, valid the cycle after the imem_rd strobe (synchronous memory, 1-cycle latency).
- redirect  in  1  load new PC and flush, pulse.
- redirect_pc  in  ADDR_W  target PC, sampled when redirect=1.
- out_valid  out  1  issued instruction valid.
- out_ready  in  1  decoder accepts this cycle.
- out_instr  out  16  first instruction word.
- out_imm  out  16  extension word; 0 when out_has_imm=0.
- out_has_imm  out  1  instruction carried an extension word.
- out_pc  out  ADDR_W  address of first word of issued instruction.
- issue_cnt  out  16  count of accepted instructions, wraps.

Behaviour:
- Extension-word opcodes (In[15:11]): 00001, 00011, 00111, 10100, 10101, 11100, 11101, 11111. All other opcodes are single-word.
- Reset (async, rst_n low):
  - state=S_IDLE, pc=RESET_PC.
  - All registered outputs 0: out_instr, out_imm, out_pc, out_has_imm, out_valid, issue_cnt.
  - imem_rd=0.
- State machine:
  - S_IDLE: imem_rd=0; next S_FETCH. Idles exactly 1 cycle after reset release.
  - S_FETCH: imem_rd=1, imem_addr=pc; next S_DECODE.
  - S_DECODE:
    - Capture imem_data into instr reg and pc into out_pc reg; pc<=pc+1.
    - If extension opcode: imem_rd=1, imem_addr=pc+1 in this cycle; next S_EXT.
    - Otherwise: imm reg<=0, has_imm<=0; next S_ISSUE.
  - S_EXT: capture imem_data into imm reg; has_imm<=1; pc<=pc+1; next S_ISSUE.
  - S_ISSUE: out_valid=1. On out_ready=1: issue_cnt++, next S_FETCH. Otherwise hold.
- Latency from the S_FETCH cycle t: out_valid at t+2 for single-word, t+3 for two-word. Throughput is one instruction per 3 or 4 cycles with out_ready held high.
- Handshake:
  - out_instr, out_imm, out_has_imm and out_pc are stable while out_valid=1 and out_ready=0.
  - No memory reads occur during S_ISSUE.
  - out_valid drops the cycle after acceptance.
- Redirect (highest priority, any state except S_IDLE):
  - pc<=redirect_pc, next state S_FETCH.
  - Any partially assembled instruction is discarded; imem_rd=0 in the redirect cycle.
  - Memory data returning in the following cycle is ignored; S_FETCH does not capture.
  - Redirect in S_ISSUE with out_ready=1 in the same cycle: the handshake completes (issue_cnt increments) and the redirect is still taken.
  - Redirect in S_ISSUE with out_ready=0: the instruction is dropped and out_valid=0 next cycle.
- Arithmetic:
  - pc increments modulo 2^ADDR_W; 0xFFFF+1 = 0x0000. An extension word of an instruction at 0xFFFF comes from 0x0000.
  - issue_cnt wraps 0xFFFF to 0x0000.
- Reset asserted mid-operation: immediate return to the reset values above; no partial issue after release.

Test Plan:
- mem[0]=0x0800, mem[1]=0x1234, mem[2]=0x6000, out_ready=1, then release reset:
  - 1st issue: instr=0x0800, imm=0x1234, has_imm=1, pc=0.
  - 2nd issue: instr=0x6000, imm=0, has_imm=0, pc=2.
  - issue_cnt=2; imem_addr sequence 0,1,2,3.
- Backpressure: out_ready=0 for 5 cycles during the 2nd issue -> outputs held constant, imem_rd=0 throughout, pc stays 3. Raise out_ready -> next fetch at addr 3.
- Redirect pulse (redirect_pc=0x0040) in S_EXT of the 0x0800 instruction -> no issue of 0x0800, next imem_addr=0x0040, issue_cnt unchanged.
- Redirect with out_ready=1 in S_ISSUE -> issue_cnt increments once, next fetch at redirect_pc.
- RESET_PC=0xFFFF, mem[0xFFFF]=0xF800 (opcode 11111), mem[0]=0xABCD -> issue instr=0xF800, imm=0xABCD, pc=0xFFFF; next fetch at 0x0001.
- rst_n low for 1 cycle while out_valid=1 -> out_valid=0 and all outputs 0 immediately; after release, one S_IDLE cycle with imem_rd=0, then fetch at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: reads one word per cycle from synchronous imem,
// pairs extension-word opcodes with their immediate, and issues over valid/ready.
module instr_fetch_unit #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_instr,
    output logic [15:0]       out_imm,
    output logic              out_has_imm,
    output logic [ADDR_W-1:0] out_pc,
    output logic [15:0]       issue_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXT    = 3'd3,
        S_ISSUE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       imm_q, imm_d;
    logic              has_imm_q, has_imm_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [15:0]       issue_cnt_q, issue_cnt_d;
    logic              take_redirect;
    logic              need_ext;

    function automatic logic is_ext_op(input logic [4:0] op);
        case (op)
            5'b00001, 5'b00011, 5'b00111, 5'b10100,
            5'b10101, 5'b11100, 5'b11101, 5'b11111: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    assign take_redirect = redirect && (state_q != S_IDLE);
    assign need_ext      = is_ext_op(imem_data[15:11]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            imm_q       <= '0;
            has_imm_q   <= 1'b0;
            out_pc_q    <= '0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            imm_q       <= imm_d;
            has_imm_q   <= has_imm_d;
            out_pc_q    <= out_pc_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        imm_d       = imm_q;
        has_imm_d   = has_imm_q;
        out_pc_d    = out_pc_q;
        issue_cnt_d = issue_cnt_q;

        // An accepted handshake counts even when a redirect lands in the same cycle.
        if (state_q == S_ISSUE && out_ready) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
        end

        if (take_redirect) begin
            pc_d    = redirect_pc;
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_FETCH;
                S_FETCH: state_d = S_DECODE;
                S_DECODE: begin
                    instr_d  = imem_data;
                    out_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_W'(1);
                    if (need_ext) begin
                        state_d = S_EXT;
                    end else begin
                        imm_d     = '0;
                        has_imm_d = 1'b0;
                        state_d   = S_ISSUE;
                    end
                end
                S_EXT: begin
                    imm_d     = imem_data;
                    has_imm_d = 1'b1;
                    pc_d      = pc_q + ADDR_W'(1);
                    state_d   = S_ISSUE;
                end
                S_ISSUE: begin
                    if (out_ready) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_rd   = 1'b0;
        imem_addr = pc_q;
        if (!take_redirect) begin
            case (state_q)
                S_FETCH: imem_rd = 1'b1;
                S_DECODE: begin
                    imem_rd   = need_ext;
                    imem_addr = pc_q + ADDR_W'(1);
                end
                default: imem_rd = 1'b0;
            endcase
        end
    end

    assign out_valid   = (state_q == S_ISSUE);
    assign out_instr   = instr_q;
    assign out_imm     = imm_q;
    assign out_has_imm = has_imm_q;
    assign out_pc      = out_pc_q;
    assign issue_cnt   = issue_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle table for the main flow plus
// hand sequences for mid-operation reset and PC wrap at the top of memory.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, rst_n1;
    logic        imem_rd, imem_rd1;
    logic [15:0] imem_addr, imem_addr1;
    logic [15:0] imem_data, imem_data1;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_valid, out_valid1;
    logic        out_ready, out_ready1;
    logic [15:0] out_instr, out_instr1, out_imm, out_imm1;
    logic        out_has_imm, out_has_imm1;
    logic [15:0] out_pc, out_pc1, issue_cnt, issue_cnt1;

    logic [15:0] mem0 [0:65535];
    logic [15:0] mem1 [0:65535];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_imm(out_imm), .out_has_imm(out_has_imm), .out_pc(out_pc),
        .issue_cnt(issue_cnt)
    );

    instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n1), .imem_rd(imem_rd1), .imem_addr(imem_addr1),
        .imem_data(imem_data1), .redirect(1'b0), .redirect_pc(16'h0000),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_instr(out_instr1),
        .out_imm(out_imm1), .out_has_imm(out_has_imm1), .out_pc(out_pc1),
        .issue_cnt(issue_cnt1)
    );

    // Synchronous instruction memories with one-cycle read latency.
    always @(posedge clk) begin
        if (imem_rd)  imem_data  <= mem0[imem_addr];
        if (imem_rd1) imem_data1 <= mem1[imem_addr1];
    end

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_imm;
        logic        e_has;
        logic [15:0] e_pc;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tv [0:26];

    function automatic vec_t mk(input logic rdy, input logic redir, input logic [15:0] rpc,
                                input logic e_rd, input logic [15:0] e_addr,
                                input logic e_valid, input logic [15:0] e_instr,
                                input logic [15:0] e_imm, input logic e_has,
                                input logic [15:0] e_pc, input logic [15:0] e_cnt);
        vec_t v;
        v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_imm = e_imm; v.e_has = e_has;
        v.e_pc = e_pc; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem0[a] = 16'h0000;
            mem1[a] = 16'h0000;
        end
        mem0[16'h0000] = 16'h0800;
        mem0[16'h0001] = 16'h1234;
        mem0[16'h0002] = 16'h6000;
        mem0[16'h0003] = 16'h0800;
        mem0[16'h0004] = 16'h3333;
        mem0[16'h0010] = 16'h1000;
        mem0[16'h0011] = 16'h6002;
        mem0[16'h0040] = 16'h6000;
        mem0[16'h0080] = 16'h1800;
        mem0[16'h0081] = 16'h5555;
        mem1[16'hFFFF] = 16'hF800;
        mem1[16'h0000] = 16'hABCD;
        mem1[16'h0001] = 16'h6000;

        //          rdy redir rpc      rd addr     vld instr    imm      has pc       cnt
        tv[0]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd0);
        tv[1]  = mk(1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd0);
        tv[2]  = mk(1, 0, 16'h0000, 1, 16'h0001, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd0);
        tv[3]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd0);
        tv[4]  = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0800, 16'h1234, 1, 16'h0000, 16'd0);
        tv[5]  = mk(1, 0, 16'h0000, 1, 16'h0002, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd1);
        tv[6]  = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd1);
        for (int k = 7; k <= 11; k++)
            tv[k] = mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h6000, 16'h0000, 0, 16'h0002, 16'd1);
        tv[12] = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h6000, 16'h0000, 0, 16'h0002, 16'd1);
        tv[13] = mk(1, 0, 16'h0000, 1, 16'h0003, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd2);
        tv[14] = mk(1, 0, 16'h0000, 1, 16'h0004, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd2);
        tv[15] = mk(1, 1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd2);
        tv[16] = mk(1, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd2);
        tv[17] = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd2);
        tv[18] = mk(1, 1, 16'h0080, 0, 16'h0000, 1, 16'h6000, 16'h0000, 0, 16'h0040, 16'd2);
        tv[19] = mk(1, 0, 16'h0000, 1, 16'h0080, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd3);
        tv[20] = mk(1, 0, 16'h0000, 1, 16'h0081, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd3);
        tv[21] = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd3);
        tv[22] = mk(0, 1, 16'h0010, 0, 16'h0000, 1, 16'h1800, 16'h5555, 1, 16'h0080, 16'd3);
        tv[23] = mk(1, 0, 16'h0000, 1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd3);
        tv[24] = mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd3);
        tv[25] = mk(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h1000, 16'h0000, 0, 16'h0010, 16'd3);
        tv[26] = mk(1, 0, 16'h0000, 1, 16'h0011, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'd4);

        rst_n = 1'b0; rst_n1 = 1'b0;
        redirect = 1'b0; redirect_pc = 16'h0000;
        out_ready = 1'b1; out_ready1 = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("reset imem_rd",   {15'd0, imem_rd},     16'd0);
        chk("reset out_valid", {15'd0, out_valid},   16'd0);
        chk("reset has_imm",   {15'd0, out_has_imm}, 16'd0);
        chk("reset instr",     out_instr,            16'h0000);
        chk("reset imm",       out_imm,              16'h0000);
        chk("reset out_pc",    out_pc,               16'h0000);
        chk("reset issue_cnt", issue_cnt,            16'h0000);

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            rst_n       = 1'b1;
            out_ready   = tv[i].rdy;
            redirect    = tv[i].redir;
            redirect_pc = tv[i].rpc;
            #1;
            chk($sformatf("v%0d imem_rd", i),   {15'd0, imem_rd},   {15'd0, tv[i].e_rd});
            chk($sformatf("v%0d out_valid", i), {15'd0, out_valid}, {15'd0, tv[i].e_valid});
            chk($sformatf("v%0d issue_cnt", i), issue_cnt,          tv[i].e_cnt);
            if (tv[i].e_rd)
                chk($sformatf("v%0d imem_addr", i), imem_addr, tv[i].e_addr);
            if (tv[i].e_valid) begin
                chk($sformatf("v%0d out_instr", i), out_instr,            tv[i].e_instr);
                chk($sformatf("v%0d out_imm", i),   out_imm,              tv[i].e_imm);
                chk($sformatf("v%0d has_imm", i),   {15'd0, out_has_imm}, {15'd0, tv[i].e_has});
                chk($sformatf("v%0d out_pc", i),    out_pc,               tv[i].e_pc);
            end
        end

        // Reset pulse while an instruction is being offered.
        @(negedge clk);
        out_ready = 1'b0;
        redirect  = 1'b0;
        #1;
        for (int i = 0; i < 10 && !out_valid; i++) begin
            @(negedge clk);
            #1;
        end
        chk("midreset valid before", {15'd0, out_valid}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset out_valid", {15'd0, out_valid},   16'd0);
        chk("midreset instr",     out_instr,            16'h0000);
        chk("midreset imm",       out_imm,              16'h0000);
        chk("midreset has_imm",   {15'd0, out_has_imm}, 16'd0);
        chk("midreset out_pc",    out_pc,               16'h0000);
        chk("midreset issue_cnt", issue_cnt,            16'h0000);
        chk("midreset imem_rd",   {15'd0, imem_rd},     16'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post-reset idle rd",    {15'd0, imem_rd},   16'd0);
        chk("post-reset idle valid", {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        #1;
        chk("post-reset fetch rd",   {15'd0, imem_rd}, 16'd1);
        chk("post-reset fetch addr", imem_addr,        16'h0000);

        // PC wrap: two-word instruction at 0xFFFF takes its extension from 0x0000.
        @(negedge clk);
        rst_n1 = 1'b1;
        #1;
        chk("wrap idle rd", {15'd0, imem_rd1}, 16'd0);
        @(negedge clk); #1;
        chk("wrap fetch rd",   {15'd0, imem_rd1}, 16'd1);
        chk("wrap fetch addr", imem_addr1,        16'hFFFF);
        @(negedge clk); #1;
        chk("wrap ext rd",   {15'd0, imem_rd1}, 16'd1);
        chk("wrap ext addr", imem_addr1,        16'h0000);
        @(negedge clk); #1;
        chk("wrap ext-cycle rd", {15'd0, imem_rd1}, 16'd0);
        @(negedge clk); #1;
        chk("wrap valid",   {15'd0, out_valid1},   16'd1);
        chk("wrap instr",   out_instr1,            16'hF800);
        chk("wrap imm",     out_imm1,              16'hABCD);
        chk("wrap has_imm", {15'd0, out_has_imm1}, 16'd1);
        chk("wrap out_pc",  out_pc1,               16'hFFFF);
        @(negedge clk); #1;
        chk("wrap next rd",   {15'd0, imem_rd1}, 16'd1);
        chk("wrap next addr", imem_addr1,        16'h0001);
        chk("wrap issue_cnt", issue_cnt1,        16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
